// File: rtl/mem_bus_arbiter.sv
// N-channel arbiter sharing one external memory bus among requesters, with
// fixed or round-robin priority, per-channel abort and an optional bus timeout.
module mem_bus_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 1,
  parameter int TIMEOUT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_re,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  input  logic [NUM_CH-1:0]        abort,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        err,
  output logic [NUM_CH*DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        data_in,
  input  logic [DATA_W-1:0]        data_out,
  output logic                     omem_re,
  output logic                     omem_wr,
  input  logic                     mem_ready
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CH_W-1:0]          r_owner;
  logic [CH_W-1:0]          r_ptr;
  logic [CH_W-1:0]          w_win;
  logic [CH_W-1:0]          w_owner_nxt;
  logic [CH_W-1:0]          w_ptr_nxt;
  logic [NUM_CH-1:0]        w_pend;
  logic                     w_any;
  logic                     w_win_wr;
  logic                     w_abort_eff;
  logic                     w_timeout;
  logic [31:0]              r_cnt;
  logic [31:0]              w_cnt_nxt;
  logic                     r_abort;
  logic                     w_abort_nxt;
  logic                     r_re;
  logic                     r_wr;
  logic                     w_re_nxt;
  logic                     w_wr_nxt;
  logic [ADDR_W-1:0]        r_addr;
  logic [ADDR_W-1:0]        w_addr_nxt;
  logic [DATA_W-1:0]        r_wdata;
  logic [DATA_W-1:0]        w_wdata_nxt;
  logic [NUM_CH-1:0]        r_done;
  logic [NUM_CH-1:0]        r_err;
  logic [NUM_CH-1:0]        w_done_nxt;
  logic [NUM_CH-1:0]        w_err_nxt;
  logic [NUM_CH-1:0]        w_rd_we;
  logic [NUM_CH*DATA_W-1:0] r_rdata;

  assign w_pend      = (req_re | req_wr) & ~abort;
  assign w_any       = |w_pend;
  assign w_win_wr    = req_wr[w_win];
  // An abort raised in the completing cycle itself must also suppress the response.
  assign w_abort_eff = r_abort | abort[r_owner];
  assign w_timeout   = (TIMEOUT > 0) && (r_cnt == 32'(TIMEOUT - 1)) && !mem_ready;

  assign done    = r_done;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign addr    = r_addr;
  assign data_in = r_wdata;
  assign omem_re = r_re;
  assign omem_wr = r_wr;

  // Winner search runs from lowest to highest priority, so the last pending hit wins.
  always_comb begin
    logic [CH_W-1:0] idx;
    idx   = '0;
    w_win = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (ARB_MODE == 0) begin
        idx = CH_W'(k - 1);
      end else begin
        idx = CH_W'((int'(r_ptr) + k) % NUM_CH);
      end
      w_win = w_pend[idx] ? idx : w_win;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_any ? ST_BUSY : ST_IDLE;
      ST_BUSY: w_state_nxt = (mem_ready || w_timeout) ? ST_RESP : ST_BUSY;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the bus, response and bookkeeping registers
  always_comb begin
    w_re_nxt    = r_re;
    w_wr_nxt    = r_wr;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_abort_nxt = r_abort;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    w_rd_we     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_addr_nxt  = req_addr[w_win*ADDR_W +: ADDR_W];
          w_wdata_nxt = w_win_wr ? req_wdata[w_win*DATA_W +: DATA_W] : r_wdata;
          w_re_nxt    = ~w_win_wr;
          w_wr_nxt    = w_win_wr;
          w_owner_nxt = w_win;
          w_ptr_nxt   = w_win;
          w_cnt_nxt   = 32'd0;
          w_abort_nxt = 1'b0;
        end else begin
          w_re_nxt = 1'b0;
          w_wr_nxt = 1'b0;
        end
      end
      ST_BUSY: begin
        w_abort_nxt = w_abort_eff;
        w_cnt_nxt   = r_cnt + 32'd1;
        if (mem_ready || w_timeout) begin
          w_re_nxt            = 1'b0;
          w_wr_nxt            = 1'b0;
          w_done_nxt[r_owner] = ~w_abort_eff;
          w_err_nxt[r_owner]  = w_timeout & ~w_abort_eff;
          w_rd_we[r_owner]    = mem_ready & r_re & ~w_abort_eff;
        end else begin
          w_re_nxt = r_re;
          w_wr_nxt = r_wr;
        end
      end
      ST_RESP: begin
        w_abort_nxt = 1'b0;
        w_cnt_nxt   = 32'd0;
      end
      default: begin
        w_re_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_abort_nxt = 1'b0;
        w_cnt_nxt   = 32'd0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_re    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_owner <= '0;
      r_ptr   <= CH_W'(NUM_CH - 1);
      r_abort <= 1'b0;
      r_cnt   <= 32'd0;
      r_done  <= '0;
      r_err   <= '0;
      r_rdata <= '0;
    end else begin
      r_re    <= w_re_nxt;
      r_wr    <= w_wr_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_abort <= w_abort_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_rd_we[i]) begin
          r_rdata[i*DATA_W +: DATA_W] <= data_out;
        end else begin
          r_rdata[i*DATA_W +: DATA_W] <= r_rdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a round-robin instance with timeout and a
// fixed-priority instance without, driven by randomized requests and memory wait states.
module tb_mem_bus_arbiter;

  localparam int NCH = 3;
  localparam int AW  = 16;
  localparam int DW  = 32;

  typedef struct {
    int             d;
    int             ch;
    bit             err;
    logic [DW-1:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic [NCH-1:0]    req_re    [2];
  logic [NCH-1:0]    req_wr    [2];
  logic [NCH*AW-1:0] req_addr  [2];
  logic [NCH*DW-1:0] req_wdata [2];
  logic [NCH-1:0]    abort     [2];
  logic [NCH-1:0]    done      [2];
  logic [NCH-1:0]    err       [2];
  logic [NCH*DW-1:0] rdata     [2];
  logic [AW-1:0]     addr      [2];
  logic [DW-1:0]     data_in   [2];
  logic [DW-1:0]     data_out  [2];
  logic              omem_re   [2];
  logic              omem_wr   [2];
  logic              mem_ready [2];

  int total;
  int bad;
  int mode [2];
  int tmo  [2];
  int ptr  [2];
  logic [DW-1:0] m_din   [2];
  logic [DW-1:0] m_rdata [2][NCH];
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(8)) u_rr (
    .clk(clk), .rst(rst), .req_re(req_re[0]), .req_wr(req_wr[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .abort(abort[0]), .done(done[0]), .err(err[0]), .rdata(rdata[0]),
    .addr(addr[0]), .data_in(data_in[0]), .data_out(data_out[0]), .omem_re(omem_re[0]),
    .omem_wr(omem_wr[0]), .mem_ready(mem_ready[0]));

  mem_bus_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(0)) u_fx (
    .clk(clk), .rst(rst), .req_re(req_re[1]), .req_wr(req_wr[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .abort(abort[1]), .done(done[1]), .err(err[1]), .rdata(rdata[1]),
    .addr(addr[1]), .data_in(data_in[1]), .data_out(data_out[1]), .omem_re(omem_re[1]),
    .omem_wr(omem_wr[1]), .mem_ready(mem_ready[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference priority rule: lowest index, or first pending after the last winner.
  function automatic int pick(input int d, input logic [NCH-1:0] pend);
    int i;
    for (int k = 1; k <= NCH; k++) begin
      i = (mode[d] == 0) ? (k - 1) : ((ptr[d] + k) % NCH);
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      ptr[d]   = NCH - 1;
      m_din[d] = '0;
      for (int c = 0; c < NCH; c++) m_rdata[d][c] = '0;
    end
  endtask

  task automatic set_addrs(input int d);
    for (int c = 0; c < NCH; c++) begin
      req_addr[d][c*AW +: AW]  = {(AW-2)'($urandom), 2'(c)};
      req_wdata[d][c*DW +: DW] = DW'($urandom);
    end
  endtask

  // Entered and left at a falling edge of an idle cycle with requests already set.
  task automatic do_access(input int d, input int f_waits, input int f_abort);
    logic [NCH-1:0] pend, own, noise;
    int w, waits, len, ab;
    bit is_wr, tmo_hit;
    logic [DW-1:0] rd_val;
    exp_t e;
    pend = (req_re[d] | req_wr[d]) & ~abort[d];
    w = pick(d, pend);
    if (w < 0) return;
    ptr[d] = w;
    own = NCH'(1) << w;
    is_wr = req_wr[d][w];
    if (is_wr) m_din[d] = req_wdata[d][w*DW +: DW];
    waits = (f_waits >= 0) ? f_waits : int'($urandom_range(0, 11));
    tmo_hit = (tmo[d] > 0) && (waits >= tmo[d]);
    len = tmo_hit ? tmo[d] : waits + 1;
    if (f_abort == -2) ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
    else ab = f_abort;
    rd_val = DW'($urandom);
    if (ab < 0) begin
      if (!is_wr && !tmo_hit) m_rdata[d][w] = rd_val;
      e.d = d; e.ch = w; e.err = tmo_hit; e.rd = m_rdata[d][w];
      exp_q.push_back(e);
    end
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      chk("busy_re", 64'(omem_re[d]), 64'(!is_wr));
      chk("busy_wr", 64'(omem_wr[d]), 64'(is_wr));
      chk("busy_addr", 64'(addr[d]), 64'(req_addr[d][w*AW +: AW]));
      chk("busy_wdata", 64'(data_in[d]), 64'(m_din[d]));
      mem_ready[d] = (k == waits);
      data_out[d]  = (k == waits) ? rd_val : DW'($urandom);
      noise = NCH'($urandom_range(0, 7)) & ~own;
      abort[d] = ((k == ab) ? own : '0) | (($urandom_range(0, 3) == 0) ? noise : '0);
    end
    @(negedge clk);
    mem_ready[d] = 1'b0;
    abort[d] = '0;
    chk("resp_re", 64'(omem_re[d]), 64'd0);
    chk("resp_wr", 64'(omem_wr[d]), 64'd0);
    chk("resp_done", 64'(done[d]), 64'((ab < 0) ? own : '0));
    chk("resp_err", 64'(err[d]), 64'((ab < 0 && tmo_hit) ? own : '0));
    for (int c = 0; c < NCH; c++) chk("rdata_state", 64'(rdata[d][c*DW +: DW]), 64'(m_rdata[d][c]));
    req_re[d][w] = 1'b0;
    req_wr[d][w] = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_round(input int d);
    logic [NCH-1:0] re, wr;
    re = NCH'($urandom);
    wr = NCH'($urandom);
    if ((re | wr) == '0) re = NCH'(1) << $urandom_range(0, NCH - 1);
    set_addrs(d);
    req_re[d] = re;
    req_wr[d] = wr;
    while ((req_re[d] | req_wr[d]) != '0) do_access(d, -1, -2);
  endtask

  // All channels hold reads with mem_ready tied high; completions every third cycle.
  task automatic hold_test(input int d);
    logic [DW-1:0] vals [12];
    int seq [4];
    exp_t e;
    for (int c = 0; c < 12; c++) vals[c] = DW'($urandom);
    for (int j = 0; j < 4; j++) begin
      seq[j] = pick(d, {NCH{1'b1}});
      ptr[d] = seq[j];
      m_rdata[d][seq[j]] = vals[3*j+1];
      e.d = d; e.ch = seq[j]; e.err = 1'b0; e.rd = vals[3*j+1];
      exp_q.push_back(e);
    end
    set_addrs(d);
    req_re[d] = '1;
    req_wr[d] = '0;
    mem_ready[d] = 1'b1;
    data_out[d] = vals[0];
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      chk("hold_done", 64'(done[d]), 64'((c % 3 == 2) ? (NCH'(1) << seq[c/3]) : '0));
      data_out[d] = vals[c];
      if (c == 11) begin
        req_re[d] = '0;
        mem_ready[d] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Scoreboard monitor: every presented completion must match the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && (done[d] != '0 || err[d] != '0)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'({done[d], err[d]}), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mon_dut", 64'(d), 64'(mon_e.d));
          chk("mon_done", 64'(done[d]), 64'(NCH'(1) << mon_e.ch));
          chk("mon_err", 64'(err[d]), 64'(mon_e.err ? (NCH'(1) << mon_e.ch) : '0));
          chk("mon_rdata", 64'(rdata[d][mon_e.ch*DW +: DW]), 64'(mon_e.rd));
        end
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    mode[0] = 1; tmo[0] = 8;
    mode[1] = 0; tmo[1] = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_re[d] = '0; req_wr[d] = '0; req_addr[d] = '0; req_wdata[d] = '0;
      abort[d] = '0; data_out[d] = '0; mem_ready[d] = 1'b0;
    end
    reset_model();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_done", 64'(done[d]), 64'd0);
      chk("rst_err", 64'(err[d]), 64'd0);
      chk("rst_rdata", 64'(rdata[d][DW-1:0]), 64'd0);
      chk("rst_addr", 64'(addr[d]), 64'd0);
      chk("rst_data_in", 64'(data_in[d]), 64'd0);
      chk("rst_re", 64'(omem_re[d]), 64'd0);
      chk("rst_wr", 64'(omem_wr[d]), 64'd0);
    end
    rst = 1'b0;

    // single read, zero wait states
    set_addrs(0);
    req_addr[0][0 +: AW] = 16'h0100;
    req_re[0] = 3'b001;
    do_access(0, 0, -1);
    // write with four wait states
    req_addr[0][AW +: AW] = 16'h0040;
    req_wdata[0][DW +: DW] = 32'h1234_5678;
    req_wr[0] = 3'b010;
    do_access(0, 4, -1);
    // timeout on ch0 with ch1 waiting
    req_re[0] = 3'b011;
    do_access(0, 20, -1);
    do_access(0, 1, -1);
    // abort in the second busy cycle, ready in the fourth
    req_re[0] = 3'b010;
    do_access(0, 3, 1);
    req_re[0] = 3'b001;
    do_access(0, 2, -1);

    hold_test(0);
    hold_test(1);

    // reset while a wait-stated read is in flight
    set_addrs(0);
    req_re[0] = 3'b100;
    mem_ready[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_re", 64'(omem_re[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_re", 64'(omem_re[0]), 64'd0);
    chk("midrst_wr", 64'(omem_wr[0]), 64'd0);
    chk("midrst_done", 64'(done[0]), 64'd0);
    rst = 1'b0;
    reset_model();
    req_re[0] = 3'b111;
    while ((req_re[0] | req_wr[0]) != '0) do_access(0, -1, -1);

    for (int r = 0; r < 25; r++) begin
      run_round(0);
      run_round(1);
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
